sa_ctrl: RTL and testbench

SA_CTRL -- requirements
Module: sa_ctrl

---
 rtl/sa_pkg.sv | 35 +++
 rtl/sa_skew_gen.sv | 24 ++
 rtl/sa_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sa_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared types and sizing helpers for the systolic-array controller.
// The state enum and the counter-width helpers live here so that the
// controller, its sub-modules and any surrounding datapath agree on them.
package sa_pkg;

    // Controller phases, in run order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } sa_state_t;

    localparam int SA_DEFAULT_WIDTH = 8;
    localparam int SA_DEFAULT_SIZE  = 10;
    localparam int SA_MIN_SIZE      = 2;

    // Width of a counter that indexes one of SIZE rows (w_row, drain counter).
    function automatic int row_cnt_w(input int size);
        return $clog2(size);
    endfunction

    // Width of the stream-step counter, which must reach 2*SIZE-2.
    function automatic int step_cnt_w(input int size);
        return $clog2(2 * size);
    endfunction

    // Number of unstalled STREAM cycles needed to skew SIZE columns through
    // SIZE rows.
    function automatic int stream_steps(input int size);
        return 2 * size - 1;
    endfunction

endpackage

// File: rtl/sa_skew_gen.sv
// sa_skew_gen: per-row input-valid generator for the skewed operand feed.
// Row r is fed during stream steps r .. r+SIZE-1, so the valid vector is a
// SIZE-wide window sliding across the rows as feed_cnt advances.
module sa_skew_gen #(
    parameter int SIZE = 10
) (
    input  logic [$clog2(2*SIZE)-1:0] feed_cnt,
    input  logic                      enable,
    output logic [SIZE-1:0]           in_valid
);

    // Decode the sliding row window for the current stream step.
    always_comb begin
        // NOTE: default every bit first so no path through the loop leaves
        // in_valid unassigned, which would infer a latch.
        in_valid = '0;
        for (int r = 0; r < SIZE; r++) begin
            if (enable && (int'(feed_cnt) >= r) && (int'(feed_cnt) < r + SIZE)) begin
                in_valid[r] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_ctrl.sv
// sa_ctrl: run sequencer for a SIZE x SIZE weight-stationary systolic array.
// One run: clear accumulators, load SIZE weight rows, stream 2*SIZE-1 skewed
// input steps, drain SIZE cycles, then pulse done/res_capture.
// src_valid low stalls weight loading and streaming; abort cancels a run.
// Optional feature: define SA_CTRL_PERF_EN to add the perf_cycles and
// stall_cycles run-statistics outputs.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH,
    parameter int SIZE  = SA_DEFAULT_SIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      src_valid,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      w_load,
    output logic [$clog2(SIZE)-1:0]   w_row,
    output logic [$clog2(2*SIZE)-1:0] feed_cnt,
    output logic [SIZE-1:0]           in_valid,
    output logic                      acc_clear,
    output logic                      res_capture
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [31:0]               perf_cycles,
    output logic [31:0]               stall_cycles
`endif
);

    localparam int ROW_W  = row_cnt_w(SIZE);
    localparam int STEP_W = step_cnt_w(SIZE);

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SIZE - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(stream_steps(SIZE) - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    // An out-of-range configuration (array smaller than 2x2 or zero-width
    // operands) keeps the controller parked in IDLE instead of sequencing a
    // datapath that cannot exist.
    localparam bit CFG_OK = (SIZE >= SA_MIN_SIZE) && (WIDTH >= 1);

    sa_state_t        state;
    logic [ROW_W-1:0] drain_cnt;
    logic             start_ok;
    logic             stream_en;

    assign start_ok = start && CFG_OK;

    // Strobes that must drop in the same cycle the source stalls are decoded
    // from the registered state and the live src_valid.
    assign w_load    = (state == LOAD_W) && src_valid;
    assign stream_en = (state == STREAM) && src_valid;

    // Accumulators are cleared during the cycle in which start is accepted,
    // so the first streamed product lands in a clean accumulator.
    assign acc_clear = (state == IDLE) && start_ok && !reset;

    sa_skew_gen #(
        .SIZE (SIZE)
    ) u_skew_gen (
        .feed_cnt (feed_cnt),
        .enable   (stream_en),
        .in_valid (in_valid)
    );

    // Run sequencer: state, phase counters and registered status outputs.
    always_ff @(posedge clk) begin
        // NOTE: every register here is assigned with <= so all of them update
        // from the same pre-edge values; blocking = would let later
        // statements see half-updated state.
        if (reset) begin
            state       <= IDLE;
            w_row       <= '0;
            feed_cnt    <= '0;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            res_capture <= 1'b0;
        end else begin
            done        <= 1'b0;
            res_capture <= 1'b0;
            if (abort && (state != IDLE)) begin
                // Abort wins over stalls and over the DRAIN -> DONE step, and
                // throws away all run progress.
                state     <= IDLE;
                busy      <= 1'b0;
                w_row     <= '0;
                feed_cnt  <= '0;
                drain_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state <= LOAD_W;
                            busy  <= 1'b1;
                            w_row <= '0;
                        end
                    end
                    LOAD_W: begin
                        if (src_valid) begin
                            if (w_row == ROW_LAST) begin
                                state    <= STREAM;
                                w_row    <= '0;
                                feed_cnt <= '0;
                            end else begin
                                w_row <= w_row + ROW_ONE;
                            end
                        end
                    end
                    STREAM: begin
                        if (src_valid) begin
                            if (feed_cnt == STEP_LAST) begin
                                state     <= DRAIN;
                                feed_cnt  <= '0;
                                drain_cnt <= '0;
                            end else begin
                                feed_cnt <= feed_cnt + STEP_ONE;
                            end
                        end
                    end
                    DRAIN: begin
                        // The pipeline empties at a fixed rate, independent
                        // of the operand source.
                        if (drain_cnt == ROW_LAST) begin
                            state       <= DONE;
                            drain_cnt   <= '0;
                            done        <= 1'b1;
                            res_capture <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + ROW_ONE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SA_CTRL_PERF_EN
    // Run statistics: perf_cycles reads k in the k-th cycle after start was
    // accepted and freezes at its DONE value; stall_cycles counts cycles
    // lost to src_valid in LOAD_W/STREAM. Both hold until the next start.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles  <= '0;
            stall_cycles <= '0;
        end else if ((state == IDLE) && start_ok) begin
            perf_cycles  <= 32'd1;
            stall_cycles <= '0;
        end else if (!abort && ((state == LOAD_W) || (state == STREAM) || (state == DRAIN))) begin
            perf_cycles <= perf_cycles + 32'd1;
            if ((state != DRAIN) && !src_valid) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: self-checking bench for sa_ctrl (SIZE=10).
// A run-progress model (one integer of completed work steps per run) predicts
// every output each cycle; directed scenarios pin absolute timings with
// literal expectations, and a randomized phase exercises stalls, aborts,
// stray starts and resets. Build with SA_CTRL_PERF_EN to cover the
// statistics outputs as well.
module tb_sa_ctrl;

    localparam int WIDTH = 8;
    localparam int SIZE  = 10;
    localparam int RW    = $clog2(SIZE);
    localparam int SW    = $clog2(2 * SIZE);

    // Work-step boundaries of one run, counted from the first LOAD_W cycle.
    localparam int STREAM_BEGIN = SIZE;           // first stream step
    localparam int DRAIN_BEGIN  = 3 * SIZE - 1;   // first drain step
    localparam int DONE_STEP    = 4 * SIZE - 1;   // the DONE cycle

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            src_valid = 1'b1;
    logic            abort = 1'b0;
    logic            busy, done, w_load, acc_clear, res_capture;
    logic [RW-1:0]   w_row;
    logic [SW-1:0]   feed_cnt;
    logic [SIZE-1:0] in_valid;
`ifdef SA_CTRL_PERF_EN
    logic [31:0]     perf_cycles, stall_cycles;
`endif

    sa_ctrl #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_valid   (src_valid),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .w_load      (w_load),
        .w_row       (w_row),
        .feed_cnt    (feed_cnt),
        .in_valid    (in_valid),
        .acc_clear   (acc_clear),
        .res_capture (res_capture)
`ifdef SA_CTRL_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit m_known  = 1'b0;
    bit m_active = 1'b0;
    int m_prog   = 0;
    int m_start_cyc = 0;
    int m_stall  = 0;
    bit m_hold_ok = 1'b0;
    int m_hold_perf  = 0;
    int m_hold_stall = 0;

    // Observations of DUT timing for the directed scenarios.
    int wl_first, wl_last, st_first, st_last;
    int done_cnt, done_first, done_last;
    logic [SIZE-1:0] iv_at0, iv_at9, iv_at18;
    int perf_at_done, stall_at_done;

    task automatic clear_obs();
        wl_first = -1; wl_last = -1; st_first = -1; st_last = -1;
        done_cnt = 0; done_first = -1; done_last = -1;
        iv_at0 = 'x; iv_at9 = 'x; iv_at18 = 'x;
        perf_at_done = -1; stall_at_done = -1;
    endtask

    always @(negedge clk) begin
        logic [SIZE-1:0] e_iv;
        bit e_load, e_stream, e_done;
        int e_row, e_feed;
        if (m_known) begin
            e_load   = m_active && (m_prog < STREAM_BEGIN);
            e_stream = m_active && (m_prog >= STREAM_BEGIN) && (m_prog < DRAIN_BEGIN);
            e_done   = m_active && (m_prog == DONE_STEP);
            e_row    = e_load ? m_prog : 0;
            e_feed   = e_stream ? (m_prog - STREAM_BEGIN) : 0;
            e_iv     = '0;
            for (int r = 0; r < SIZE; r++)
                if (e_stream && src_valid && (e_feed >= r) && (e_feed < r + SIZE)) e_iv[r] = 1'b1;
            check("busy",        busy,        m_active);
            check("done",        done,        e_done);
            check("res_capture", res_capture, e_done);
            check("w_load",      w_load,      e_load && src_valid);
            check("w_row",       w_row,       e_row);
            check("feed_cnt",    feed_cnt,    e_feed);
            check("in_valid",    in_valid,    e_iv);
            check("acc_clear",   acc_clear,   !m_active && start && !reset);
`ifdef SA_CTRL_PERF_EN
            if (e_done) begin
                check("perf_at_done",  perf_cycles,  cyc - m_start_cyc);
                check("stall_at_done", stall_cycles, m_stall);
            end else if (!m_active && m_hold_ok) begin
                check("perf_held",  perf_cycles,  m_hold_perf);
                check("stall_held", stall_cycles, m_hold_stall);
            end
`endif
        end

        // Timing observations for the directed scenarios.
        if (w_load === 1'b1) begin
            if (wl_first < 0) wl_first = cyc;
            wl_last = cyc;
        end
        if (in_valid !== '0 && ^in_valid !== 1'bx) begin
            if (st_first < 0) st_first = cyc;
            st_last = cyc;
            if (feed_cnt == SW'(0))  iv_at0  = in_valid;
            if (feed_cnt == SW'(9))  iv_at9  = in_valid;
            if (feed_cnt == SW'(18)) iv_at18 = in_valid;
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (done_first < 0) done_first = cyc;
            done_last = cyc;
`ifdef SA_CTRL_PERF_EN
            perf_at_done  = int'(perf_cycles);
            stall_at_done = int'(stall_cycles);
`endif
        end

        // Advance the model by the inputs the DUT samples at the next edge.
        if (reset) begin
            m_known = 1'b1; m_active = 1'b0; m_prog = 0;
            m_hold_ok = 1'b1; m_hold_perf = 0; m_hold_stall = 0;
        end else if (m_known) begin
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1; m_prog = 0; m_start_cyc = cyc;
                    m_stall = 0; m_hold_ok = 1'b0;
                end
            end else if (m_prog == DONE_STEP) begin
                m_active = 1'b0; m_hold_ok = 1'b1;
                m_hold_perf = cyc - m_start_cyc; m_hold_stall = m_stall;
            end else if (abort) begin
                m_active = 1'b0;
            end else if (m_prog < DRAIN_BEGIN) begin
                if (src_valid) m_prog++;
                else m_stall++;
            end else begin
                m_prog++;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    int c0 = 0;

    task automatic goto(input int n);
        while (cyc < c0 + n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_obs();
        @(posedge clk); #1;
        c0 = cyc;
    endtask

    initial begin
        clear_obs();
        @(posedge clk); #1;

        // Nominal run: timing of every phase.
        do_reset();
        check("reset_outputs", {busy, done, w_load, w_row, feed_cnt, in_valid, acc_clear, res_capture}, 0);
        start = 1'b1;
        goto(1); start = 1'b0;
        goto(45);
        check("s1_wload_first",  wl_first - c0, 1);
        check("s1_wload_last",   wl_last - c0,  10);
        check("s1_stream_first", st_first - c0, 11);
        check("s1_stream_last",  st_last - c0,  29);
        check("s1_done_cycle",   done_first - c0, 40);
        check("s1_done_count",   done_cnt, 1);
        check("s1_iv_feed0",     iv_at0,  10'b0000000001);
        check("s1_iv_feed9",     iv_at9,  10'b1111111111);
        check("s1_iv_feed18",    iv_at18, 10'b1000000000);

        // Three stalled cycles mid-stream.
        do_reset();
        start = 1'b1;
        goto(1); start = 1'b0;
        goto(15); src_valid = 1'b0;
        goto(17);
        check("s2_feed_frozen",  feed_cnt, 4);
        check("s2_iv_stalled",   in_valid, 0);
        goto(18); src_valid = 1'b1;
        goto(48);
        check("s2_done_cycle",   done_first - c0, 43);
        check("s2_done_count",   done_cnt, 1);
`ifdef SA_CTRL_PERF_EN
        check("s2_perf_cycles",  perf_at_done, 43);
        check("s2_stall_cycles", stall_at_done, 3);
`endif

        // Abort mid-run, then a fresh run.
        do_reset();
        start = 1'b1;
        goto(1); start = 1'b0;
        goto(15); abort = 1'b1;
        goto(16); abort = 1'b0;
        check("s3_busy_after_abort", busy, 0);
        goto(20); start = 1'b1;
        goto(21); start = 1'b0;
        goto(65);
        check("s3_done_cycle", done_first - c0, 60);
        check("s3_done_count", done_cnt, 1);

        // Stray starts while busy, then reset mid-run.
        do_reset();
        start = 1'b1;
        goto(1);  start = 1'b0;
        goto(5);  start = 1'b1;
        goto(6);  start = 1'b0;
        goto(12); start = 1'b1;
        goto(13); start = 1'b0;
        goto(24);
        check("s4_feed_unaffected", feed_cnt, 13);
        goto(25); reset = 1'b1;
        goto(26); reset = 1'b0;
`ifdef SA_CTRL_PERF_EN
        check("s4_perf_reset", {perf_cycles, stall_cycles}, 0);
`endif
        check("s4_outputs_after_reset", {busy, done, w_load, w_row, feed_cnt, in_valid, acc_clear, res_capture}, 0);
        goto(30); start = 1'b1;
        goto(31); start = 1'b0;
        check("s4_fresh_load", {busy, w_load, w_row}, {1'b1, 1'b1, RW'(0)});
        goto(75);
        check("s4_done_cycle", done_first - c0, 70);
        check("s4_done_count", done_cnt, 1);

        // Back-to-back runs.
        do_reset();
        start = 1'b1;
        goto(1);  start = 1'b0;
        goto(41); start = 1'b1;
        goto(42); start = 1'b0;
        goto(85);
        check("s5_first_done",  done_first - c0, 40);
        check("s5_second_done", done_last - c0,  81);
        check("s5_done_count",  done_cnt, 2);

        // Randomized traffic against the model.
        do_reset();
        repeat (4000) begin
            @(posedge clk); #1;
            start     = ($urandom_range(0, 9) == 0);
            src_valid = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 299) == 0);
            reset     = ($urandom_range(0, 999) == 0);
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b1;
        @(posedge clk); #1;
        check("rand_runs_completed", done_cnt > 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
